// File: rtl/rom_io.sv
// ---------------------------------------------------------------------------
// rom_io -- 256 x 8 program ROM with an optional 4-bit I/O port and a
// Wishbone backdoor for loading and inspecting program storage.
//
// The block follows an 8-phase bus cycle:
//   A1 A2 A3 M1 M2 X1 X2 X3
// - A1/A2/A3: capture the fetch address nibbles and the chip number.
// - M1/M2:    drive the opcode nibbles (OPR, OPA) when this chip is selected.
// - X2:       I/O port activity (SRC select, WRR write, RDR read).
// - X3:       Wishbone backdoor access slot.
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   data_i / data_o / data_en resolved bus in, driven value, drive enable
//   sync                      instruction-cycle marker (asserted in X3)
//   cmd_n                     active-low command line
//   io_i / io_o               I/O port pins in / registered pins out
//   wb_*                      Wishbone backdoor (byte address, 8-bit data)
//
// Configuration
//   ROM_IO_PORT_EN  define to build the I/O port (SRC/WRR/RDR handling).
//                   Without it io_o is tied to 4'h0 and X2 never drives.
// ---------------------------------------------------------------------------
module rom_io #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  data_i,
    output logic [3:0]  data_o,
    output logic        data_en,
    input  logic        sync,
    input  logic        cmd_n,
    input  logic [3:0]  io_i,
    output logic [3:0]  io_o,
    input  logic [31:0] wb_data_i,
    input  logic [31:0] wb_addr_i,
    input  logic        wb_cyc_i,
    input  logic        wb_strobe_i,
    input  logic        wb_we_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o
);

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    phase_t      phase;
    phase_t      phase_next;
    logic [7:0]  addr;
    logic        rom_sel;
    logic [7:0]  fetch_byte;
    logic [7:0]  mem [256];
    logic [7:0]  wb_index;
    logic        wb_service;

    // Only the word index bits of the address and the low data byte matter.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_addr_i[31:10], wb_addr_i[1:0], wb_data_i[31:8]};

    assign wb_index   = wb_addr_i[9:2];
    // The ack check makes a held request take one slot per instruction cycle.
    assign wb_service = !reset && (phase == PH_X3) && wb_cyc_i && wb_strobe_i && !wb_ack_o;

    // -----------------------------------------------------------------------
    // Phase counter: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            phase <= PH_A1;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        // sync re-aligns the counter to A1 even if it lands mid-cycle.
        if (sync) begin
            phase_next = PH_A1;
        end else begin
            phase_next = phase_t'(phase + 3'd1);
        end
    end

`ifdef ROM_IO_PORT_EN
    localparam logic [3:0] INST_WRR = 4'h2;
    localparam logic [3:0] INST_RDR = 4'hA;

    logic       io_sel;
    logic [3:0] io_inst;
    logic       io_active;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        data_o  = 4'h0;
        data_en = 1'b0;
        case (phase)
            PH_M1: begin
                if (rom_sel) begin
                    data_o  = fetch_byte[7:4];
                    data_en = 1'b1;
                end
            end
            PH_M2: begin
                if (rom_sel) begin
                    data_o  = fetch_byte[3:0];
                    data_en = 1'b1;
                end
            end
`ifdef ROM_IO_PORT_EN
            PH_X2: begin
                if (io_active && (io_inst == INST_RDR)) begin
                    data_o  = io_i;
                    data_en = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Fetch address capture, chip select and Wishbone acknowledge
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            addr     <= 8'h00;
            rom_sel  <= 1'b0;
            wb_ack_o <= 1'b0;
        end else begin
            if (phase == PH_A1) addr[3:0] <= data_i;
            if (phase == PH_A2) addr[7:4] <= data_i;
            if (phase == PH_A3) rom_sel   <= (data_i == CHIP_ID);
            wb_ack_o <= wb_service;
        end
    end

    // -----------------------------------------------------------------------
    // Program storage. The fetch read (A3) and backdoor access (X3) sit in
    // different phases, so a single port serves both without arbitration.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: no reset here -- the loaded program must survive reset, and
        // fetch_byte / wb_data_o are don't-care until first written.
        if (phase == PH_A3) begin
            fetch_byte <= mem[addr];
        end
        if (wb_service) begin
            wb_data_o <= {24'h0, mem[wb_index]};
            if (wb_we_i) begin
                mem[wb_index] <= wb_data_i[7:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // I/O port
    // -----------------------------------------------------------------------
`ifdef ROM_IO_PORT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            io_sel    <= 1'b0;
            io_inst   <= 4'h0;
            io_active <= 1'b0;
            io_o      <= 4'h0;
        end else begin
            // SRC in X2 selects (or deselects) this chip's port; held otherwise.
            if ((phase == PH_X2) && !cmd_n) begin
                io_sel <= (data_i == CHIP_ID);
            end
            // The I/O instruction nibble arrives on the OPA slot.
            if ((phase == PH_M2) && !cmd_n && io_sel) begin
                io_inst   <= data_i;
                io_active <= 1'b1;
            end
            if ((phase == PH_X2) && io_active && (io_inst == INST_WRR)) begin
                io_o <= data_i;
            end
            if (phase == PH_X3) begin
                io_active <= 1'b0;
            end
        end
    end
`else
    logic unused_io_bits;
    assign unused_io_bits = ^{io_i, cmd_n};
    assign io_o = 4'h0;
`endif

endmodule
